// File: rtl/text_pixel_gen.sv
// Text-mode pixel engine. Tracks the character cell under the beam, fetches
// the character code from text RAM, addresses the font ROM, and serialises
// each returned glyph line into one pixel per clock. The pipeline is three
// stages deep: de_in is sampled in stage 0 and emerges as de_out three
// cycles later. A block cursor covers the bottom two scan lines of its cell
// and blinks with the MSB of a free-running frame counter.
module text_pixel_gen #(
  parameter int TEXT_COLS  = 80,
  parameter int TEXT_ROWS  = 30,
  parameter int ADDR_WIDTH = 12,
  parameter int COL_WIDTH  = 7,
  parameter int ROW_WIDTH  = 6,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic                  de_in,
  input  logic [1:0]            font_sel,
  input  logic                  cursor_en,
  input  logic [COL_WIDTH-1:0]  cursor_col,
  input  logic [ROW_WIDTH-1:0]  cursor_row,
  output logic [ADDR_WIDTH-1:0] text_addr,
  input  logic [7:0]            char_code,
  output logic [1:0]            font_num,
  output logic [3:0]            line_num,
  output logic [7:0]            char_num,
  input  logic [7:0]            rom_data,
  output logic                  pixel,
  output logic                  de_out
);

  // ---------------------------------------------------------------------
  // Beam-position counters
  // ---------------------------------------------------------------------
  logic [1:0]            font_lat_q,  font_lat_d;
  logic [3:0]            scan_line_q, scan_line_d;
  logic [ROW_WIDTH-1:0]  row_q,       row_d;
  logic [ADDR_WIDTH-1:0] row_base_q,  row_base_d;
  logic [COL_WIDTH-1:0]  col_q,       col_d;
  logic [2:0]            pix_bit_q,   pix_bit_d;
  logic [BLINK_LOG2-1:0] frame_cnt_q, frame_cnt_d;

  // Stage 1 registers (RAM data and ROM address phase)
  logic [ADDR_WIDTH-1:0] text_addr_q, text_addr_d;
  logic [3:0]            s1_line_q,   s1_line_d;
  logic [2:0]            s1_bit_q,    s1_bit_d;
  logic                  s1_de_q,     s1_de_d;
  logic                  s1_blank_q,  s1_blank_d;
  logic                  s1_cur_q,    s1_cur_d;

  // Stage 2 registers (ROM data phase)
  logic [2:0]            s2_bit_q;
  logic                  s2_de_q;
  logic                  s2_blank_q;
  logic                  s2_cur_q;

  // Output stage
  logic                  pixel_q,     pixel_d;
  logic                  de_out_q;

  // Derived cell geometry
  logic [4:0]            cell_h;
  logic                  last_line;
  logic                  cursor_line;
  logic                  glyph_bit;

  // Cell height from the latched font; font 3 is unpopulated in the ROM but
  // still steps through 16 scan lines so the frame geometry stays sane.
  always_comb begin
    cell_h = 5'd16;
    case (font_lat_q)
      2'd0:    cell_h = 5'd8;
      2'd1:    cell_h = 5'd14;
      default: cell_h = 5'd16;
    endcase
  end

  assign last_line   = ({1'b0, scan_line_q} == (cell_h - 5'd1));
  assign cursor_line = ({1'b0, scan_line_q} >= (cell_h - 5'd2));

  // Counter next-state: frame_start overrides line_start, which overrides
  // the per-pixel advance.
  always_comb begin
    font_lat_d  = font_lat_q;
    scan_line_d = scan_line_q;
    row_d       = row_q;
    row_base_d  = row_base_q;
    col_d       = col_q;
    pix_bit_d   = pix_bit_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start) begin
      font_lat_d  = font_sel;
      scan_line_d = 4'd0;
      row_d       = '0;
      row_base_d  = '0;
      col_d       = '0;
      pix_bit_d   = 3'd0;
      frame_cnt_d = frame_cnt_q + 1'b1;
    end else if (line_start) begin
      col_d     = '0;
      pix_bit_d = 3'd0;
      if (last_line) begin
        scan_line_d = 4'd0;
        row_d       = row_q + 1'b1;
        row_base_d  = row_base_q + ADDR_WIDTH'(TEXT_COLS);
      end else begin
        scan_line_d = scan_line_q + 4'd1;
      end
    end else if (de_in) begin
      if (pix_bit_q == 3'd7) begin
        pix_bit_d = 3'd0;
        col_d     = col_q + 1'b1;
      end else begin
        pix_bit_d = pix_bit_q + 3'd1;
      end
    end
  end

  // Stage 0: capture the cell address and per-pixel attributes. The text
  // address only moves on active pixels; everything else shifts every cycle.
  always_comb begin
    text_addr_d = text_addr_q;
    if (de_in) begin
      text_addr_d = row_base_q + ADDR_WIDTH'(col_q);
    end
    s1_line_d  = scan_line_q;
    s1_bit_d   = pix_bit_q;
    s1_de_d    = de_in;
    s1_blank_d = (col_q >= COL_WIDTH'(TEXT_COLS)) |
                 (row_q >= ROW_WIDTH'(TEXT_ROWS));
    s1_cur_d   = cursor_en & (col_q == cursor_col) & (row_q == cursor_row) &
                 cursor_line & ~frame_cnt_q[BLINK_LOG2-1];
  end

  // Stage 2: pick the glyph bit (MSB first), apply cursor and blanking.
  assign glyph_bit = rom_data[3'd7 - s2_bit_q];

  always_comb begin
    pixel_d = s2_de_q & ~s2_blank_q & (glyph_bit ^ s2_cur_q);
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      font_lat_q  <= 2'd0;
      scan_line_q <= 4'd0;
      row_q       <= '0;
      row_base_q  <= '0;
      col_q       <= '0;
      pix_bit_q   <= 3'd0;
      frame_cnt_q <= '0;
    end else begin
      font_lat_q  <= font_lat_d;
      scan_line_q <= scan_line_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
      col_q       <= col_d;
      pix_bit_q   <= pix_bit_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Pipeline registers; reset flushes every stage so nothing in flight
  // reaches the output after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      text_addr_q <= '0;
      s1_line_q   <= 4'd0;
      s1_bit_q    <= 3'd0;
      s1_de_q     <= 1'b0;
      s1_blank_q  <= 1'b0;
      s1_cur_q    <= 1'b0;
      s2_bit_q    <= 3'd0;
      s2_de_q     <= 1'b0;
      s2_blank_q  <= 1'b0;
      s2_cur_q    <= 1'b0;
      pixel_q     <= 1'b0;
      de_out_q    <= 1'b0;
    end else begin
      text_addr_q <= text_addr_d;
      s1_line_q   <= s1_line_d;
      s1_bit_q    <= s1_bit_d;
      s1_de_q     <= s1_de_d;
      s1_blank_q  <= s1_blank_d;
      s1_cur_q    <= s1_cur_d;
      s2_bit_q    <= s1_bit_q;
      s2_de_q     <= s1_de_q;
      s2_blank_q  <= s1_blank_q;
      s2_cur_q    <= s1_cur_q;
      pixel_q     <= pixel_d;
      de_out_q    <= s2_de_q;
    end
  end

  // Font ROM address is formed from the RAM data plus stage-1 state, so the
  // ROM sees a consistent {font, line, char} triple in the same cycle.
  assign text_addr = text_addr_q;
  assign char_num  = char_code;
  assign line_num  = s1_line_q;
  assign font_num  = font_lat_q;
  assign pixel     = pixel_q;
  assign de_out    = de_out_q;

endmodule

// File: tb/tb_text_pixel_gen.sv
// Self-checking bench for text_pixel_gen. Text RAM returns addr[7:0] in the
// cycle the address is presented; the font ROM is a one-cycle registered
// lookup returning char ^ line (0 for font 3). Expected pixels are pushed to
// a queue as de_in is driven and popped whenever de_out is high.
module tb_text_pixel_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        line_start;
  logic        de_in;
  logic [1:0]  font_sel;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic [11:0] text_addr;
  logic [7:0]  char_code;
  logic [1:0]  font_num;
  logic [3:0]  line_num;
  logic [7:0]  char_num;
  logic [7:0]  rom_data;
  logic        pixel;
  logic        de_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];
  bit mon_en = 1'b0;

  // Bench-side model of the beam position
  int row_m, line_m, frame_m, font_m;
  bit cen_m;
  int ccol_m, crow_m;

  always #5 clk = ~clk;

  text_pixel_gen dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .line_start (line_start),
    .de_in      (de_in),
    .font_sel   (font_sel),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .text_addr  (text_addr),
    .char_code  (char_code),
    .font_num   (font_num),
    .line_num   (line_num),
    .char_num   (char_num),
    .rom_data   (rom_data),
    .pixel      (pixel),
    .de_out     (de_out)
  );

  // Text RAM model
  assign char_code = text_addr[7:0];

  // Font ROM model
  always @(posedge clk)
    rom_data <= (font_num == 2'd3) ? 8'h00 : (char_num ^ {4'h0, line_num});

  function automatic int cell_h(input int f);
    if (f == 0) return 8;
    if (f == 1) return 14;
    return 16;
  endfunction

  function automatic bit exp_pixel(input int c, input int b);
    logic [11:0] a;
    logic [7:0]  ch;
    logic [7:0]  g;
    bit          blank;
    bit          cur;
    a     = 12'((row_m * 80 + c) % 4096);
    ch    = a[7:0];
    g     = (font_m == 3) ? 8'h00 : (ch ^ 8'(line_m));
    blank = (c >= 80) || (row_m >= 30);
    cur   = cen_m && (c == ccol_m) && (row_m == crow_m) &&
            (line_m >= cell_h(font_m) - 2) && (((frame_m >> 4) & 1) == 0);
    return !blank && (g[7 - b] ^ cur);
  endfunction

  // Scoreboard monitor: sample away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (de_out === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_de_out: de_out=1 but no pixel expected");
        end else begin
          bit e;
          e = exp_q.pop_front();
          if (pixel !== e) begin
            n_fail++;
            $display("FAIL pixel: got %b expected %b (t=%0t)", pixel, e, $time);
          end
        end
      end else begin
        n_checks++;
        if (pixel !== 1'b0 || de_out !== 1'b0) begin
          n_fail++;
          $display("FAIL idle: pixel=%b de_out=%b expected 0/0", pixel, de_out);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    de_in       = 1'b0;
    font_sel    = 2'd0;
    cursor_en   = 1'b0;
    cursor_col  = 7'd0;
    cursor_row  = 6'd0;
    tick();
    tick();
    reset   = 1'b0;
    row_m   = 0;
    line_m  = 0;
    frame_m = 0;
    font_m  = 0;
    cen_m   = 1'b0;
    ccol_m  = 0;
    crow_m  = 0;
    exp_q.delete();
    mon_en  = 1'b1;
  endtask

  task automatic start_frame(input int f);
    font_sel    = 2'(f);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    frame_m = (frame_m + 1) % 32;
    font_m  = f;
    row_m   = 0;
    line_m  = 0;
  endtask

  task automatic next_line();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    if (line_m == cell_h(font_m) - 1) begin
      line_m = 0;
      row_m++;
    end else begin
      line_m++;
    end
  endtask

  // Drive n characters of active pixels on the current line and drain
  task automatic render(input int n, input bit chk_lat);
    int k;
    k = 0;
    for (int c = 0; c < n; c++) begin
      for (int b = 0; b < 8; b++) begin
        exp_q.push_back(exp_pixel(c, b));
        de_in = 1'b1;
        tick();
        n_checks++;
        if (text_addr !== 12'((row_m * 80 + c) % 4096)) begin
          n_fail++;
          $display("FAIL text_addr: got %0d expected %0d", text_addr, (row_m * 80 + c) % 4096);
        end
        n_checks++;
        if (line_num !== 4'(line_m) || font_num !== 2'(font_m)) begin
          n_fail++;
          $display("FAIL rom_addr: line_num=%0d font_num=%0d expected %0d/%0d",
                   line_num, font_num, line_m, font_m);
        end
        if (chk_lat && k < 4) begin
          n_checks++;
          if (de_out !== (k >= 2)) begin
            n_fail++;
            $display("FAIL de_latency: cycle %0d de_out=%b expected %b", k + 1, de_out, (k >= 2));
          end
        end
        k++;
      end
    end
    de_in = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pixels never produced, expected 0 left", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (text_addr !== 12'd0 || pixel !== 1'b0 || de_out !== 1'b0 ||
        font_num !== 2'd0 || line_num !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: addr=%0d pix=%b de=%b font=%0d line=%0d expected all 0",
               text_addr, pixel, de_out, font_num, line_num);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    start_frame(0);
    render(2, 1'b1);
    n_checks++;
    if (text_addr !== 12'd1) begin
      n_fail++;
      $display("FAIL basic_last_addr: got %0d expected 1", text_addr);
    end
    next_line();
    render(4, 1'b1);
    $display("test_basic done");
  endtask

  task automatic test_font1_rows();
    do_reset();
    start_frame(1);
    render(1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      next_line();
      render(1, 1'b0);
    end
    n_checks++;
    if (text_addr !== 12'd80 || line_num !== 4'd0) begin
      n_fail++;
      $display("FAIL font1_wrap: addr=%0d line=%0d expected 80/0", text_addr, line_num);
    end
    $display("test_font1_rows done");
  endtask

  task automatic test_font_latch();
    do_reset();
    start_frame(0);
    next_line();
    font_sel = 2'd2;
    render(1, 1'b0);
    n_checks++;
    if (font_num !== 2'd0) begin
      n_fail++;
      $display("FAIL font_midframe: got %0d expected 0", font_num);
    end
    start_frame(2);
    n_checks++;
    if (font_num !== 2'd2) begin
      n_fail++;
      $display("FAIL font_latched: got %0d expected 2", font_num);
    end
    render(1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      next_line();
      render(1, 1'b0);
    end
    n_checks++;
    if (line_num !== 4'd15) begin
      n_fail++;
      $display("FAIL font2_height: line_num=%0d expected 15", line_num);
    end
    next_line();
    render(1, 1'b0);
    n_checks++;
    if (text_addr !== 12'd80 || line_num !== 4'd0) begin
      n_fail++;
      $display("FAIL font2_wrap: addr=%0d line=%0d expected 80/0", text_addr, line_num);
    end
    $display("test_font_latch done");
  endtask

  task automatic cursor_pass();
    start_frame(1);
    render(3, 1'b0);
    for (int i = 0; i < 27; i++) begin
      next_line();
      render(3, 1'b0);
    end
  endtask

  task automatic test_cursor();
    do_reset();
    cursor_en  = 1'b1;
    cursor_col = 7'd2;
    cursor_row = 6'd1;
    cen_m  = 1'b1;
    ccol_m = 2;
    crow_m = 1;
    cursor_pass();
    for (int i = 0; i < 14; i++) start_frame(1);
    cursor_pass();
    cursor_en = 1'b0;
    cen_m     = 1'b0;
    $display("test_cursor done (frame count %0d)", frame_m);
  endtask

  task automatic test_blank_col();
    do_reset();
    start_frame(0);
    render(81, 1'b0);
    $display("test_blank_col done");
  endtask

  task automatic test_reset_midline();
    do_reset();
    start_frame(0);
    for (int i = 0; i < 9; i++) next_line();
    mon_en = 1'b0;
    de_in  = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    de_in = 1'b0;
    reset = 1'b1;
    tick();
    n_checks++;
    if (text_addr !== 12'd0 || pixel !== 1'b0 || de_out !== 1'b0 || line_num !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_midline: addr=%0d pix=%b de=%b line=%0d expected 0/0/0/0",
               text_addr, pixel, de_out, line_num);
    end
    reset   = 1'b0;
    row_m   = 0;
    line_m  = 0;
    frame_m = 0;
    font_m  = 0;
    exp_q.delete();
    mon_en  = 1'b1;
    render(2, 1'b1);
    $display("test_reset_midline done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_font1_rows();
    test_font_latch();
    test_cursor();
    test_blank_col();
    test_reset_midline();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
